// File: rtl/a2d_pkg.sv
// rtl/a2d_pkg.sv - shared slot, channel and state definitions for the pot sequencer
// Contents: slot_e (scan slots), state_e (sequencer states), SLOT_CHNL_TBL
// (slot -> ADC channel), slot_chnl() and next_slot() helpers, datapath widths.
package a2d_pkg;

  localparam int POT_W     = 12;
  localparam int SMOOTH_W  = 14;
  localparam int NUM_SLOTS = 6;

  // Scan order; the encoding is also the index into the pot register file.
  typedef enum logic [2:0] {
    SLOT_LP  = 3'd0,
    SLOT_B1  = 3'd1,
    SLOT_B2  = 3'd2,
    SLOT_B3  = 3'd3,
    SLOT_HP  = 3'd4,
    SLOT_VOL = 3'd5
  } slot_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_STORE = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  // Three bits per slot, slot 0 in the LSBs: LP=1, B1=0, B2=4, B3=2, HP=3, VOL=7.
  localparam logic [17:0] SLOT_CHNL_TBL = {3'd7, 3'd3, 3'd2, 3'd4, 3'd0, 3'd1};

  function automatic logic [2:0] slot_chnl(input slot_e s);
    logic [4:0] idx;
    idx = {2'b00, s} * 5'd3;
    return SLOT_CHNL_TBL[idx +: 3];
  endfunction

  function automatic slot_e next_slot(input slot_e s);
    return (s == SLOT_VOL) ? SLOT_LP : slot_e'(s + 3'd1);
  endfunction

endpackage

// File: rtl/pot_smooth.sv
// rtl/pot_smooth.sv - first-order smoothing of a new pot reading (A2D_SMOOTH_EN builds only)
// Ports: old   in  12  value currently held in the slot register
//        res   in  12  new conversion result
//        first in  1   slot has never stored since reset; pass res through
//        val   out 12  value to write: res, or (3*old + res) >> 2
// The module only exists when A2D_SMOOTH_EN is defined.
`ifdef A2D_SMOOTH_EN
module pot_smooth
  import a2d_pkg::*;
(
  input  logic [POT_W-1:0] old,
  input  logic [POT_W-1:0] res,
  input  logic             first,
  output logic [POT_W-1:0] val
);

  // 3*4095 + 4095 = 16380 fits the 14-bit sum exactly.
  logic [SMOOTH_W-1:0] old_w;
  logic [SMOOTH_W-1:0] sum;

  assign old_w = {2'b00, old};
  assign sum   = (old_w << 1) + old_w + {2'b00, res};
  assign val   = first ? res : sum[SMOOTH_W-1:2];

endmodule
`endif

// File: rtl/a2d_pot_seq.sv
// rtl/a2d_pot_seq.sv - round-robin A2D pot scanner with priority VOLUME requests
// Parameters: GAP_CYC idle clocks between conversions, TMO_CYC clocks allowed for cnv_cmplt.
// Ports: clk, rst_n (async active-low); cnv_cmplt/res from the A2D SPI block;
//        vol_req priority VOLUME request pulse; strt_cnv/chnnl to the A2D SPI block;
//        LP, B1, B2, B3, HP, VOLUME latest readings; scan_done round pulse;
//        all_valid every slot stored once; err sticky timeout.
// Build option: A2D_SMOOTH_EN selects smoothed stores via pot_smooth.
module a2d_pot_seq
  import a2d_pkg::*;
#(
  parameter logic [15:0] GAP_CYC = 16'd1024,
  parameter logic [15:0] TMO_CYC = 16'd4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  input  logic        vol_req,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  output logic [11:0] LP,
  output logic [11:0] B1,
  output logic [11:0] B2,
  output logic [11:0] B3,
  output logic [11:0] HP,
  output logic [11:0] VOLUME,
  output logic        scan_done,
  output logic        all_valid,
  output logic        err
);

  state_e               state_q, state_d;
  slot_e                ptr_q;        // round-robin position
  slot_e                cur_q;        // slot of the conversion in flight
  slot_e                launch_slot;
  logic                 cur_pri_q;    // conversion in flight is a priority VOLUME
  logic                 pending_q;
  logic [15:0]          cnt_q;        // shared WAIT timeout / GAP counter
  logic [POT_W-1:0]     res_q;
  logic [POT_W-1:0]     wr_val;
  logic [POT_W-1:0]     pot_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] valid_q;
  logic                 launch;
  logic                 do_store;
  logic                 tmo_hit;
  logic                 slot_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    strt_cnv = 1'b0;
    launch   = 1'b0;
    do_store = 1'b0;
    tmo_hit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_START;
        launch  = 1'b1;
      end
      ST_START: begin
        strt_cnv = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        // A completion on the final timeout clock still counts as a completion.
        if (cnv_cmplt) begin
          state_d = ST_STORE;
        end else if (cnt_q == TMO_CYC - 16'd1) begin
          state_d = ST_GAP;
          tmo_hit = 1'b1;
        end
      end
      ST_STORE: begin
        do_store = 1'b1;
        state_d  = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_q == GAP_CYC - 16'd1) begin
          state_d = ST_START;
          launch  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A pending priority request steals the next START without moving ptr_q.
  assign launch_slot = pending_q ? SLOT_VOL : ptr_q;
  assign slot_done   = do_store | tmo_hit;

`ifdef A2D_SMOOTH_EN
  pot_smooth u_smooth (
    .old   (pot_q[cur_q]),
    .res   (res_q),
    .first (~valid_q[cur_q]),
    .val   (wr_val)
  );
`else
  assign wr_val = res_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= SLOT_LP;
      cur_q     <= SLOT_LP;
      cur_pri_q <= 1'b0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      res_q     <= '0;
      valid_q   <= '0;
      chnnl     <= '0;
      scan_done <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) pot_q[i] <= '0;
    end else begin
      // Restart counting on every state change so WAIT and GAP each begin at 0.
      cnt_q <= (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;

      // A request arriving on the consuming clock survives as a new pending.
      pending_q <= vol_req | (pending_q & ~launch);

      if (launch) begin
        cur_q     <= launch_slot;
        cur_pri_q <= pending_q;
        chnnl     <= slot_chnl(launch_slot);
      end

      if (state_q == ST_WAIT && cnv_cmplt) res_q <= res;

      if (do_store) begin
        pot_q[cur_q]   <= wr_val;
        valid_q[cur_q] <= 1'b1;
      end

      if (tmo_hit) err <= 1'b1;

      if (slot_done && !cur_pri_q) ptr_q <= next_slot(ptr_q);
      scan_done <= slot_done && !cur_pri_q && (ptr_q == SLOT_HP);
    end
  end

  assign LP        = pot_q[SLOT_LP];
  assign B1        = pot_q[SLOT_B1];
  assign B2        = pot_q[SLOT_B2];
  assign B3        = pot_q[SLOT_B3];
  assign HP        = pot_q[SLOT_HP];
  assign VOLUME    = pot_q[SLOT_VOL];
  assign all_valid = &valid_q;

endmodule

// File: tb/tb_a2d_pot_seq.sv
// tb/tb_a2d_pot_seq.sv - self-checking bench for a2d_pot_seq
module tb_a2d_pot_seq;

  localparam logic [15:0] GAP = 16'd8;
  localparam logic [15:0] TMO = 16'd16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        vol_req;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic [11:0] LP, B1, B2, B3, HP, VOLUME;
  logic        scan_done;
  logic        all_valid;
  logic        err;

  always #10 clk = ~clk;

  a2d_pot_seq #(.GAP_CYC(GAP), .TMO_CYC(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cnv_cmplt (cnv_cmplt),
    .res       (res),
    .vol_req   (vol_req),
    .strt_cnv  (strt_cnv),
    .chnnl     (chnnl),
    .LP        (LP),
    .B1        (B1),
    .B2        (B2),
    .B3        (B3),
    .HP        (HP),
    .VOLUME    (VOLUME),
    .scan_done (scan_done),
    .all_valid (all_valid),
    .err       (err)
  );

  int checks = 0;
  int passed = 0;

  // Reference model: slot list in scan order, expected readings, pending flag.
  int CH [6] = '{1, 0, 4, 2, 3, 7};
  int m_pot [6];
  bit m_valid [6];
  int m_rr;
  bit m_pending;
  bit m_err;
  bit gap_known;

  function automatic logic [11:0] dut_pot(input int s);
    case (s)
      0: return LP;
      1: return B1;
      2: return B2;
      3: return B3;
      4: return HP;
      default: return VOLUME;
    endcase
  endfunction

  function automatic int model_store(input int old, input int r, input bit first);
`ifdef A2D_SMOOTH_EN
    if (!first) return (3 * old + r) / 4;
`endif
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_pot[i]   = 0;
      m_valid[i] = 1'b0;
    end
    m_rr      = 0;
    m_pending = 1'b0;
    m_err     = 1'b0;
    gap_known = 1'b0;
  endtask

  // One conversion: wait for strt_cnv, check channel/gap, answer or withhold,
  // then check every output against the model.
  task automatic convert(input bit respond, input bit pulse_vol, input bit use_fixed,
                         input logic [11:0] fixed);
    int n, slot, w, lat;
    bit pri, exp_scan, exp_all;
    logic [11:0] r, e;
    logic [2:0] exp_ch;
    n = 0;
    while (strt_cnv !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (strt_cnv !== 1'b1) begin
      $display("FAIL strt_wait: strt_cnv=%b after %0d clocks, required 1", strt_cnv, n);
      return;
    end
    passed++;
    if (gap_known) begin
      // One GAP clock was already consumed by the previous call.
      checks++;
      if (n !== int'(GAP) - 1) $display("FAIL gap_len: %0d clocks, required %0d", n + 1, GAP);
      else passed++;
    end
    if (m_pending) begin
      slot = 5; pri = 1'b1; m_pending = 1'b0;
    end else begin
      slot = m_rr; pri = 1'b0;
    end
    exp_ch = CH[slot][2:0];
    checks++;
    if (chnnl !== exp_ch) $display("FAIL chnnl: got %0d required %0d", chnnl, exp_ch);
    else passed++;

    @(negedge clk);
    w = 1;
    checks++;
    if (strt_cnv !== 1'b0 || chnnl !== exp_ch)
      $display("FAIL strt_pulse: strt_cnv=%b chnnl=%0d required 0/%0d", strt_cnv, chnnl, exp_ch);
    else passed++;

    if (pulse_vol) begin
      vol_req = 1'b1;
      @(negedge clk);
      vol_req = 1'b0;
      w++;
      m_pending = 1'b1;
    end

    if (respond) begin
      lat = $urandom_range(0, 3);
      repeat (lat) @(negedge clk);
      r = use_fixed ? fixed : 12'($urandom);
      cnv_cmplt = 1'b1;
      res = r;
      @(negedge clk);
      cnv_cmplt = 1'b0;
      res = 12'($urandom);
      @(negedge clk);
      m_pot[slot]   = model_store(m_pot[slot], int'(r), !m_valid[slot]);
      m_valid[slot] = 1'b1;
    end else begin
      while (w < int'(TMO)) begin
        @(negedge clk);
        w++;
      end
      checks++;
      if (err !== m_err) $display("FAIL err_early: got %b required %b at WAIT clock %0d", err, m_err, w);
      else passed++;
      @(negedge clk);
      m_err = 1'b1;
    end

    exp_scan = !pri && (slot == 4);
    if (!pri) m_rr = (m_rr + 1) % 6;
    exp_all = 1'b1;
    for (int s = 0; s < 6; s++) begin
      exp_all = exp_all & m_valid[s];
      e = m_pot[s][11:0];
      checks++;
      if (dut_pot(s) !== e) $display("FAIL pot_%0d: got %h required %h", s, dut_pot(s), e);
      else passed++;
    end
    checks++;
    if (scan_done !== exp_scan) $display("FAIL scan_done: got %b required %b", scan_done, exp_scan);
    else passed++;
    checks++;
    if (all_valid !== exp_all) $display("FAIL all_valid: got %b required %b", all_valid, exp_all);
    else passed++;
    checks++;
    if (err !== m_err) $display("FAIL err: got %b required %b", err, m_err);
    else passed++;

    // Stray completion during GAP must be ignored.
    cnv_cmplt = 1'b1;
    res = 12'($urandom);
    @(negedge clk);
    cnv_cmplt = 1'b0;
    checks++;
    if (scan_done !== 1'b0) $display("FAIL scan_pulse: got %b required 0", scan_done);
    else passed++;
    gap_known = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cnv_cmplt = 1'b0;
    vol_req = 1'b0;
    res = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (strt_cnv !== 1'b0 || chnnl !== 3'd0 || scan_done !== 1'b0 || all_valid !== 1'b0 || err !== 1'b0)
      $display("FAIL reset_ctl: strt=%b ch=%0d scan=%b av=%b err=%b required all 0",
               strt_cnv, chnnl, scan_done, all_valid, err);
    else passed++;
    for (int s = 0; s < 6; s++) begin
      checks++;
      if (dut_pot(s) !== 12'h000) $display("FAIL reset_pot_%0d: got %h required 000", s, dut_pot(s));
      else passed++;
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_full_round();
    for (int i = 0; i < 6; i++) convert(1'b1, 1'b0, 1'b1, 12'hA5A);
    checks++;
    if (all_valid !== 1'b1 || LP !== 12'hA5A || VOLUME !== 12'hA5A)
      $display("FAIL round_a5a: av=%b LP=%h VOL=%h required 1/a5a/a5a", all_valid, LP, VOLUME);
    else passed++;
  endtask

  task automatic test_vol_priority();
    convert(1'b1, 1'b0, 1'b0, 12'h0);
    convert(1'b1, 1'b1, 1'b0, 12'h0);
    convert(1'b1, 1'b0, 1'b0, 12'h0);
    convert(1'b1, 1'b0, 1'b0, 12'h0);
  endtask

  task automatic test_timeout();
    convert(1'b0, 1'b0, 1'b0, 12'h0);
    convert(1'b1, 1'b0, 1'b0, 12'h0);
    checks++;
    if (err !== 1'b1) $display("FAIL err_sticky: got %b required 1", err);
    else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++)
      convert($urandom_range(0, 5) != 0, $urandom_range(0, 3) == 0, 1'b0, 12'h0);
  endtask

  task automatic test_reset_mid_wait();
    int n;
    n = 0;
    while (strt_cnv !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (strt_cnv !== 1'b0 || chnnl !== 3'd0 || err !== 1'b0 || all_valid !== 1'b0 ||
        LP !== 12'h0 || B1 !== 12'h0 || B2 !== 12'h0 || B3 !== 12'h0 || HP !== 12'h0 || VOLUME !== 12'h0)
      $display("FAIL async_reset: strt=%b ch=%0d err=%b av=%b LP=%h VOL=%h required all 0",
               strt_cnv, chnnl, err, all_valid, LP, VOLUME);
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    convert(1'b1, 1'b0, 1'b0, 12'h0);
  endtask

`ifdef A2D_SMOOTH_EN
  task automatic test_smooth();
    test_reset();
    convert(1'b1, 1'b0, 1'b1, 12'h000);
    for (int i = 0; i < 5; i++) convert(1'b1, 1'b0, 1'b0, 12'h0);
    convert(1'b1, 1'b0, 1'b1, 12'h400);
    checks++;
    if (LP !== 12'h100) $display("FAIL smooth_lp: got %h required 100", LP);
    else passed++;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_round();
    test_vol_priority();
    test_timeout();
    test_random();
    test_reset_mid_wait();
`ifdef A2D_SMOOTH_EN
    test_smooth();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/a2d_pot_seq.md
A2D_POT_SEQ -- requirements
Module: a2d_pot_seq

Interface
REQ-001 Parameter GAP_CYC, default 16'd1024, idle clocks between conversions.
REQ-002 Parameter TMO_CYC, default 16'd4096, clocks allowed for cnv_cmplt before timeout.
REQ-003 clk  in  1  system clock (50 MHz).
REQ-004 rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 cnv_cmplt  in  1  one-clock pulse from A2D SPI interface; conversion result valid.
REQ-006 res  in  12  conversion result; sampled only when cnv_cmplt=1.
REQ-007 vol_req  in  1  one-clock pulse requesting a priority VOLUME conversion.
REQ-008 strt_cnv  out  1  one-clock pulse starting a conversion.
REQ-009 chnnl  out  3  ADC channel; held stable from strt_cnv until cnv_cmplt or timeout.
REQ-010 LP, B1, B2, B3, HP, VOLUME  out  12 each  latest pot readings.
REQ-011 scan_done  out  1  one-clock pulse when slot HP stores and a full round has completed.
REQ-012 all_valid  out  1  high once every one of the six slots has stored at least once.
REQ-013 err  out  1  sticky timeout flag.

Function
REQ-014 Slot order SHALL be LP(ch1), B1(ch0), B2(ch4), B3(ch2), HP(ch3), VOLUME(ch7), then wrap to LP.
REQ-015 FSM states SHALL be IDLE, START, WAIT, STORE, GAP.
REQ-016 IDLE -> START on the first clock after reset release.
REQ-017 START: assert strt_cnv for exactly one clock with chnnl set; -> WAIT.
REQ-018 WAIT: cnv_cmplt -> STORE; timeout counter reaching TMO_CYC-1 -> GAP with err set, no store, slot advances.
REQ-019 STORE: write res to the slot's output register one clock after cnv_cmplt; -> GAP.
REQ-020 GAP: count GAP_CYC clocks, then -> START with next slot.
REQ-021 vol_req SHALL be latched as pending; at the next START, VOLUME (ch7) is converted instead, and the round-robin pointer is not advanced.
REQ-022 vol_req arriving while a priority conversion is already in progress SHALL set pending again (one further VOLUME slot); multiple requests SHALL merge into one.
REQ-023 Priority VOLUME conversions SHALL NOT assert scan_done or advance the round.
REQ-024 cnv_cmplt outside WAIT SHALL be ignored.
REQ-025 scan_done SHALL assert the clock after the HP store or HP timeout.

Reset
REQ-026 On rst_n low, all outputs SHALL go to 0, state to IDLE, pointer to LP, pending cleared, and counters cleared immediately, including mid-conversion.
REQ-027 err SHALL clear only on reset.

Configuration
REQ-028 With A2D_SMOOTH_EN defined, STORE SHALL write (3*old + res) >> 2 using 14-bit intermediate arithmetic; the first store to a slot after reset SHALL write res directly.
REQ-029 Without A2D_SMOOTH_EN, STORE SHALL write res unmodified.

Structure
REQ-030 Shared package a2d_pkg SHALL hold the slot enum, the slot-to-channel constant table, and the state typedef.
REQ-031 The smoothing datapath SHALL be sub-module pot_smooth, instantiated only under A2D_SMOOTH_EN.

Verification
REQ-032 Reset release, ADC model returns 12'hA5A on every channel -> chnnl sequence 1,0,4,2,3,7; all six outputs = 12'hA5A; all_valid after the 6th store; one scan_done pulse.
REQ-033 GAP_CYC=8 -> exactly 8 clocks between STORE and the next strt_cnv.
REQ-034 vol_req during the B1 conversion -> next strt_cnv uses ch7, then ch4 (B2); no extra scan_done.
REQ-035 cnv_cmplt withheld on B3 with TMO_CYC=16 -> err=1 after 16 WAIT clocks; B3 holds its old value; next chnnl=3.
REQ-036 rst_n low during WAIT -> strt_cnv=0 and outputs=0 immediately; after release the scan restarts at ch1.
REQ-037 With A2D_SMOOTH_EN, LP=12'h000 stored, then res=12'h400 -> LP=12'h100.
